reflet_bus_arbiter: RTL and testbench
=====================================

# reflet_bus_arbiter

Two-master memory bus arbiter for the Reflet system. It shares one synchronous-read memory bus between two requesters: port 0 is normally `reflet_cpu`, port 1 a DMA or debug engine. It sequences every access as an address phase followed by a response phase, and uses round-robin priority with optional bounded bus locking. Its memory-side outputs are zero whenever it is idle, so the memory-side data return works with the codebase's OR-combined data bus (ROM | RAM | peripherals).

## Interface
Parameters:
- `wordsize`, 16: width of addresses and data on all ports.
- `max_lock`, 8: maximum consecutive grants to a locking master while the other master is waiting. Range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1: access request. Hold high until ack.
- `m0_lock`, `m1_lock` in 1: asks to keep ownership for the next access.
- `m0_addr`, `m1_addr` in `wordsize`: address. Must be stable from req until ack.
- `m0_wdata`, `m1_wdata` in `wordsize`: write data. Must be stable from req until ack.
- `m0_write_en`, `m1_write_en` in 1: 1 = write, 0 = read. Must be stable from req until ack.
- `m0_rdata`, `m1_rdata` out `wordsize`: read data. Valid only while the matching ack is high, 0 otherwise.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `mem_addr` out `wordsize`, `mem_data_out` out `wordsize`, `mem_write_en` out 1, `mem_enable` out 1: memory command.
- `mem_data_in` in `wordsize`: memory read data, valid one cycle after the address.
- `owner` out 1: index of the granted master. Meaningful only when `mem_enable` or an ack is high.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, arbitrate, register the chosen master into `owner`, and go to ACCESS.
- ACCESS:
  - `mem_enable`=1.
  - `mem_addr`, `mem_data_out` and `mem_write_en` are muxed from the owner.
  - Always go to RESP.
- RESP:
  - `mem_enable`=0 and `mem_write_en`=0.
  - The owner's ack=1, and its rdata = `mem_data_in`. Writes also ack; their rdata content is don't-care but must be driven 0.
  - Arbitrate again using the requests sampled in this cycle, excluding the owner's current request, which is being acked.
  - If a request wins, go to ACCESS; otherwise go to IDLE.
- Arbitration, in priority order:
  - Lock hold: if the owner had lock=1 during this transaction, its req is high again at the next decision, and `lock_cnt` < `max_lock`, the owner keeps the bus. If the other master is not requesting, the owner keeps the bus regardless of `lock_cnt`.
  - Otherwise round-robin: the master not served last wins a tie. A single requester always wins.
- `lock_cnt`, 8 bits:
  - Increments on each consecutive grant to the same master while the other master's req is high.
  - Resets to 0 on a change of owner, or whenever the other master is not requesting.
- `last` holds the previously served master; reset value is 1, so m0 wins the first tie.
- In IDLE and RESP, all `mem_*` outputs are 0. A non-owner's ack and rdata are always 0.

## Timing
- Reset (`reset`=0) acts immediately, mid-transaction included:
  - State goes to IDLE; `owner`=0, `last`=1, `lock_cnt`=0.
  - All acks, rdata and `mem_*` outputs go to 0.
  - An in-flight access is dropped with no ack; the master re-issues it.
- Latency from idle: req high in cycle n gives ACCESS in n+1 and ack in n+2.
- Throughput is one access per 2 cycles. Back-to-back ACCESS/RESP pairs run with no IDLE gap.
- A write reaches memory at the rising edge that ends the ACCESS cycle.
- A master that drops req before ack leaves the bus in undefined behaviour; benches must not do this.
- If both reqs rise in the same cycle from IDLE, round-robin alone decides.
- The ack cycle counts as the master's next request only if req is still high in the following decision. Masters lower req in the ack cycle if they are done.

## Test plan
- Single read:
  - Stimulus: m0 reads addr 0x0040, memory returns 0xABCD one cycle later.
  - Required: `mem_enable` in cycle 1, `m0_ack`=1 with `m0_rdata`=0xABCD in cycle 2, then IDLE with all `mem_*` outputs 0.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 both request continuously, no lock.
  - Required: grants alternate m0, m1, m0, m1; one ack every 2 cycles.
- Write:
  - Stimulus: m1 writes 0x1234 to addr 0x0400.
  - Required: `mem_write_en`=1, `mem_addr`=0x0400 and `mem_data_out`=0x1234 for exactly one cycle; `m1_ack` the next cycle with `m1_rdata`=0.
- Lock bound:
  - Stimulus: `max_lock`=3; m0 holds lock and req continuously; m1 requests throughout.
  - Required: m0 is granted 4 consecutive times (initial grant + 3), then m1 once, then m0 again.
- Lock without contention:
  - Stimulus: m0 locked for 20 accesses, m1 idle.
  - Required: 20 consecutive m0 grants with no forced rotation.
- Reset mid-access:
  - Stimulus: drop `reset` during the ACCESS cycle of m1.
  - Required: outputs go to 0 in the same cycle with no `m1_ack`; after release, the first tie goes to m0.

Source files
------------

// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded locking.
// Address phase then response phase; idle memory outputs are zero.
module reflet_bus_arbiter #(
  parameter int wordsize = 16,
  parameter int max_lock = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic                m0_lock,
  input  logic                m1_lock,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m0_write_en,
  input  logic                m1_write_en,
  output logic [wordsize-1:0] m0_rdata,
  output logic [wordsize-1:0] m1_rdata,
  output logic                m0_ack,
  output logic                m1_ack,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  output logic                mem_enable,
  input  logic [wordsize-1:0] mem_data_in,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic       last;
  logic       lock_q;
  logic       wr_q;
  logic [7:0] lock_cnt;

  logic       r0, r1;
  logic       own_req, oth_req;
  logic       hold;
  logic       grant, win, win_oth;
  logic [7:0] cnt_nxt;

  // In RESP the owner's pending req is the one being acked,
  // so it only counts toward a lock hold, never round-robin.
  always_comb begin
    r0 = m0_req;
    r1 = m1_req;
    own_req = owner ? m1_req : m0_req;
    oth_req = owner ? m0_req : m1_req;
    hold = (state == RESP) && lock_q && own_req &&
           (!oth_req || lock_cnt < 8'(max_lock));
    if (state == RESP) begin
      if (owner) r1 = 1'b0;
      else r0 = 1'b0;
    end
    grant = 1'b0;
    win = 1'b0;
    if (state == ACCESS) begin
      grant = 1'b0;
    end else if (hold) begin
      grant = 1'b1;
      win = owner;
    end else if (r0 && r1) begin
      grant = 1'b1;
      win = ~last;
    end else if (r0 || r1) begin
      grant = 1'b1;
      win = r1;
    end
    win_oth = win ? m0_req : m1_req;
    cnt_nxt = (win == last && win_oth) ? lock_cnt + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      lock_cnt     <= 8'd0;
      lock_q       <= 1'b0;
      wr_q         <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      mem_enable   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      mem_enable   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      unique case (state)
        IDLE, RESP: begin
          if (grant) begin
            state        <= ACCESS;
            owner        <= win;
            last         <= win;
            lock_cnt     <= cnt_nxt;
            lock_q       <= win ? m1_lock : m0_lock;
            wr_q         <= win ? m1_write_en : m0_write_en;
            mem_enable   <= 1'b1;
            mem_write_en <= win ? m1_write_en : m0_write_en;
            mem_addr     <= win ? m1_addr : m0_addr;
            mem_data_out <= win ? m1_wdata : m0_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner) m1_ack <= 1'b1;
          else m0_ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_rdata = (m0_ack && !wr_q) ? mem_data_in : '0;
  assign m1_rdata = (m1_ack && !wr_q) ? mem_data_in : '0;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Bench for reflet_bus_arbiter: phase-level model, per-cycle compare,
// directed scenarios with literal grant sequences.
module tb_reflet_bus_arbiter;

  localparam int W = 16;
  localparam int MAXL = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m1_req, m0_lock, m1_lock;
  logic [W-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic         m0_write_en, m1_write_en;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic         m0_ack, m1_ack;
  logic [W-1:0] mem_addr, mem_data_out, mem_data_in;
  logic         mem_write_en, mem_enable, owner;

  reflet_bus_arbiter #(.wordsize(W), .max_lock(MAXL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_write_en(m0_write_en), .m1_write_en(m1_write_en),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .mem_enable(mem_enable),
    .mem_data_in(mem_data_in), .owner(owner)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_log(string nm, int act[$], int exp[$]);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %p expected %p", nm, act, exp);
    end
  endtask

  // synchronous-read memory, outputs 0 when not enabled (OR-bus)
  logic [W-1:0] bmem [0:1023];
  logic [W-1:0] rd = '0;
  assign mem_data_in = rd;

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] <= 16'(i * 3 + 7);
    bmem[10'h040] <= 16'hABCD;
  end

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write_en) bmem[mem_addr[9:0]] <= mem_data_out;
      rd <= mem_write_en ? '0 : bmem[mem_addr[9:0]];
    end else begin
      rd <= '0;
    end
  end

  // model: phase 0 idle, 1 address, 2 response
  int  ph, mo, ml, streak;
  bit  mlk;
  bit  rq[2];
  bit  orq[2];
  int  w;
  int  mlog[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; mo = 0; ml = 1; streak = 0; mlk = 0;
    end else if (ph == 1) begin
      ph = 2;
    end else begin
      orq[0] = m0_req; orq[1] = m1_req;
      rq = orq;
      w = -1;
      if (ph == 2 && mlk && orq[mo] && (!orq[1-mo] || streak < MAXL)) begin
        w = mo;
      end else begin
        if (ph == 2) rq[mo] = 0;
        if (rq[0] && rq[1]) w = 1 - ml;
        else if (rq[0]) w = 0;
        else if (rq[1]) w = 1;
      end
      if (w < 0) begin
        ph = 0;
      end else begin
        streak = (w == ml && orq[1-w]) ? streak + 1 : 0;
        mlk = (w == 1) ? m1_lock : m0_lock;
        mo = w; ml = w; ph = 1;
        mlog.push_back(w);
      end
    end
  end

  int dlog[$];
  int acks[$];
  logic [W-1:0] e_addr, e_dout, e_rd;
  logic         e_we, e_wr;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_enable) dlog.push_back(int'(owner));
    if (m0_ack || m1_ack) acks.push_back(cyc);
    e_addr = (mo == 1) ? m1_addr : m0_addr;
    e_dout = (mo == 1) ? m1_wdata : m0_wdata;
    e_wr   = (mo == 1) ? m1_write_en : m0_write_en;
    e_we   = (ph == 1) && e_wr;
    e_rd   = (ph == 2 && !e_wr) ? bmem[e_addr[9:0]] : '0;
    chk("mem_enable", W'(mem_enable), W'(ph == 1));
    chk("mem_write_en", W'(mem_write_en), W'(e_we));
    chk("mem_addr", mem_addr, (ph == 1) ? e_addr : '0);
    chk("mem_data_out", mem_data_out, (ph == 1) ? e_dout : '0);
    chk("m0_ack", W'(m0_ack), W'(ph == 2 && mo == 0));
    chk("m1_ack", W'(m1_ack), W'(ph == 2 && mo == 1));
    chk("m0_rdata", m0_rdata, (mo == 0) ? e_rd : '0);
    chk("m1_rdata", m1_rdata, (mo == 1) ? e_rd : '0);
    if (ph != 0) chk("owner", W'(owner), W'(mo));
  end

  // masters: hold req until ack, re-request while work remains
  int n0_left = 0;
  int n1_left = 0;

  initial begin
    m0_req = 0;
    forever begin
      @(negedge clk);
      if (m0_ack) begin
        n0_left--;
        m0_addr = m0_addr + 16'd1;
        m0_wdata = m0_wdata + 16'h0011;
      end
      m0_req = (n0_left > 0);
    end
  end

  initial begin
    m1_req = 0;
    forever begin
      @(negedge clk);
      if (m1_ack) begin
        n1_left--;
        m1_addr = m1_addr + 16'd1;
        m1_wdata = m1_wdata + 16'h0101;
      end
      m1_req = (n1_left > 0);
    end
  end

  task automatic pulse_reset();
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
  endtask

  task automatic wait_done(string nm, int budget);
    int k;
    k = 0;
    while ((n0_left > 0 || n1_left > 0 || mem_enable || m0_ack || m1_ack)
           && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= budget) begin
      tests++; fails++;
      $display("FAIL %s: timeout after %0d cycles", nm, budget);
    end
    repeat (2) @(posedge clk);
    #3;
  endtask

  task automatic clear_logs();
    mlog.delete(); dlog.delete(); acks.delete();
  endtask

  task automatic chk_gaps(string nm);
    for (int i = 1; i < acks.size(); i++)
      chk(nm, W'(acks[i] - acks[i-1]), W'(2));
  endtask

  initial begin
    reset = 0;
    m0_lock = 0; m1_lock = 0;
    m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0;
    m0_write_en = 0; m1_write_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst owner", W'(owner), '0);
    chk("rst mem_enable", W'(mem_enable), '0);
    chk("rst acks", W'({m0_ack, m1_ack}), '0);
    @(negedge clk); reset = 1;
    @(posedge clk); #3;

    // single read
    m0_addr = 16'h0040; n0_left = 1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("rd access en", W'(mem_enable), W'(1));
    chk("rd access addr", mem_addr, 16'h0040);
    @(posedge clk); #1;
    chk("rd ack", W'(m0_ack), W'(1));
    chk("rd data", m0_rdata, 16'hABCD);
    chk("rd resp en", W'(mem_enable), '0);
    @(posedge clk); #1;
    chk("rd idle", {mem_addr | mem_data_out}, '0);
    chk("rd idle ctl", W'({mem_enable, mem_write_en, m0_ack}), '0);
    wait_done("read", 20);

    // simultaneous requests after reset
    pulse_reset();
    @(posedge clk); #3;
    clear_logs();
    m0_addr = 16'h0100; m1_addr = 16'h0200;
    n0_left = 4; n1_left = 4;
    wait_done("alternate", 60);
    chk_log("alt model", mlog, '{0, 1, 0, 1, 0, 1, 0, 1});
    chk_log("alt dut", dlog, '{0, 1, 0, 1, 0, 1, 0, 1});
    chk_gaps("alt ack gap");

    // write
    clear_logs();
    m1_addr = 16'h0400; m1_wdata = 16'h1234; m1_write_en = 1;
    n1_left = 1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("wr en", W'(mem_write_en), W'(1));
    chk("wr addr", mem_addr, 16'h0400);
    chk("wr data", mem_data_out, 16'h1234);
    @(posedge clk); #1;
    chk("wr ack", W'(m1_ack), W'(1));
    chk("wr rdata", m1_rdata, '0);
    chk("wr en off", W'(mem_write_en), '0);
    wait_done("write", 20);
    chk("wr mem", bmem[10'h400], 16'h1234);
    m1_write_en = 0;

    // lock bound
    pulse_reset();
    @(posedge clk); #3;
    clear_logs();
    m0_lock = 1; m0_addr = 16'h0010; m1_addr = 16'h0020;
    n0_left = 6; n1_left = 2;
    wait_done("lock bound", 80);
    chk_log("lock model", mlog, '{0, 0, 0, 0, 1, 0, 0, 1});
    chk_log("lock dut", dlog, '{0, 0, 0, 0, 1, 0, 0, 1});

    // lock without contention
    clear_logs();
    n0_left = 20;
    wait_done("lock solo", 100);
    tests++;
    if (dlog.size() != 20 || dlog.sum() != 0 || mlog != dlog) begin
      fails++;
      $display("FAIL lock solo: got %p expected 20 grants to m0", dlog);
    end
    chk("solo ack count", W'(acks.size()), W'(20));
    chk_gaps("solo ack gap");
    m0_lock = 0;

    // reset mid-access of m1
    clear_logs();
    m1_addr = 16'h0300; n1_left = 1;
    begin
      int k;
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!(mem_enable && owner) && k < 10);
      chk("m1 access seen", W'(mem_enable && owner), W'(1));
    end
    #1 reset = 0;
    #1;
    chk("mid rst en", W'(mem_enable), '0);
    chk("mid rst addr", mem_addr, '0);
    chk("mid rst ack", W'({m0_ack, m1_ack}), '0);
    chk("mid rst rdata", m1_rdata, '0);
    m0_addr = 16'h0050; n0_left = 1;
    clear_logs();
    @(posedge clk);
    @(negedge clk); reset = 1;
    wait_done("after reset", 30);
    chk_log("rst model", mlog, '{0, 1});
    chk_log("rst dut", dlog, '{0, 1});
    chk("rst m1 acks", W'(acks.size()), W'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
